// File: rtl/video_write_queue.sv
// video_write_queue: snoops CPU bus writes that land in a video address window,
// rebases them to video-RAM offsets and queues them for a valid/ready drain.
//
// Optional build macro: VWQ_COALESCE_EN
//   When defined, a hit whose offset matches the most recently pushed entry
//   overwrites that entry's data in place instead of pushing a new entry.
//   When undefined, every hit is a separate push and no comparator exists.
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   c_addr      CPU bus address
//   c_data      CPU bus write data
//   c_we        CPU write strobe
//   v_addr      video RAM offset of head entry (0 while empty)
//   v_data      data of head entry (0 while empty)
//   v_valid     head entry present
//   v_ready     video RAM accepts the head entry this cycle
//   full        FIFO holds DEPTH entries
//   level       current entry count
//   drop_count  saturating count of writes lost to overflow
module video_write_queue #(
    parameter int                 CADDR_W   = 16,
    parameter int                 DATA_W    = 8,
    parameter int                 VADDR_W   = 15,
    parameter logic [CADDR_W-1:0] WIN_BASE  = 16'h8000,
    parameter logic [CADDR_W-1:0] WIN_LIMIT = 16'hF530,
    parameter int                 DEPTH     = 8,
    parameter int                 DROP_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CADDR_W-1:0]       c_addr,
    input  logic [DATA_W-1:0]        c_data,
    input  logic                     c_we,
    output logic [VADDR_W-1:0]       v_addr,
    output logic [DATA_W-1:0]        v_data,
    output logic                     v_valid,
    input  logic                     v_ready,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic [DROP_W-1:0]        drop_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

    logic [VADDR_W-1:0] memAddr [DEPTH];
    logic [DATA_W-1:0]  memData [DEPTH];

    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;

    logic               hit;
    logic               pop;
    logic               push;
    logic               drop;
    logic               coalesce;
    logic               wrEn;
    logic [VADDR_W-1:0] offset;
    logic [PW-1:0]      wrIdx;
    logic [PW-1:0]      wrNext;
    logic [PW-1:0]      rdNext;
    logic [PW:0]        levelNext;
    logic [VADDR_W-1:0] headAddr;
    logic [DATA_W-1:0]  headData;

`ifdef VWQ_COALESCE_EN
    logic [PW-1:0] lastPtr;
`endif

    always_comb begin
        hit = c_we && (c_addr >= WIN_BASE) && (c_addr <= WIN_LIMIT);
        // Low bits of the full-width difference equal the difference of the
        // low bits, so only VADDR_W bits of subtractor are needed.
        offset = c_addr[VADDR_W-1:0] - WIN_BASE[VADDR_W-1:0];
        pop = v_valid && v_ready;
        coalesce = 1'b0;
        wrIdx = wrPtr;
`ifdef VWQ_COALESCE_EN
        lastPtr = wrPtr - PW'(1);
        // The newest entry is the head being popped only when it is alone.
        if (hit && (level != '0) && !(pop && (level == (PW+1)'(1)))
                && (memAddr[lastPtr] == offset)) begin
            coalesce = 1'b1;
            wrIdx = lastPtr;
        end
`endif
        // A pop frees a slot in the same edge, so a full FIFO still accepts.
        push = hit && !coalesce && (!full || pop);
        drop = hit && !coalesce && full && !pop;
        wrEn = push || coalesce;

        wrNext = push ? wrPtr + PW'(1) : wrPtr;
        rdNext = pop ? rdPtr + PW'(1) : rdPtr;
        levelNext = level + (PW+1)'(push) - (PW+1)'(pop);

        // Show-ahead: the head after this edge is the post-write memory
        // contents at the post-pop read pointer.
        if (wrEn && (wrIdx == rdNext)) begin
            headAddr = offset;
            headData = c_data;
        end else begin
            headAddr = memAddr[rdNext];
            headData = memData[rdNext];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wrEn) begin
            memAddr[wrIdx] <= offset;
            memData[wrIdx] <= c_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            level      <= '0;
            full       <= 1'b0;
            drop_count <= '0;
            v_valid    <= 1'b0;
            v_addr     <= '0;
            v_data     <= '0;
        end else begin
            wrPtr <= wrNext;
            rdPtr <= rdNext;
            level <= levelNext;
            full  <= (levelNext == FULL_LVL);
            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + DROP_W'(1);
            end
            v_valid <= (levelNext != '0);
            v_addr  <= (levelNext != '0) ? headAddr : '0;
            v_data  <= (levelNext != '0) ? headData : '0;
        end
    end

endmodule

// File: tb/tb_video_write_queue.sv
// Testbench for video_write_queue: queue-based reference model with a
// scoreboard monitor comparing every drained entry.
module tb_video_write_queue;

    typedef struct packed {
        logic [14:0] a;
        logic [7:0]  d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] c_addr;
    logic [7:0]  c_data;
    logic        c_we;
    logic [14:0] v_addr;
    logic [7:0]  v_data;
    logic        v_valid;
    logic        v_ready;
    logic        full;
    logic [3:0]  level;
    logic [7:0]  drop_count;

    ent_t expQ[$];
    int   expDrop = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    video_write_queue dut (
        .clk(clk),
        .rst(rst),
        .c_addr(c_addr),
        .c_data(c_data),
        .c_we(c_we),
        .v_addr(v_addr),
        .v_data(v_data),
        .v_valid(v_valid),
        .v_ready(v_ready),
        .full(full),
        .level(level),
        .drop_count(drop_count)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every handshake must deliver the oldest expected entry.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (!rst && v_valid && v_ready) begin
                if (expQ.size() == 0) begin
                    chk("pop_unexpected", 32'(v_valid), 32'd0);
                end else begin
                    e = expQ.pop_front();
                    chk("drain_addr", 32'(v_addr), 32'(e.a));
                    chk("drain_data", 32'(v_data), 32'(e.d));
                end
            end
        end
    end

    // One clock: check post-edge state against the model, then drive the
    // next inputs and advance the model by the outcome of the coming edge.
    task automatic step(input logic we, input logic [15:0] addr,
                        input logic [7:0] data, input logic rdy,
                        input logic r);
        bit          pop;
        bit          hit;
        bit          done;
        logic [14:0] off;
        ent_t        e;
        @(posedge clk);
        #1;
        chk("level", 32'(level), 32'(expQ.size()));
        chk("full", 32'(full), 32'(expQ.size() == 8));
        chk("drops", 32'(drop_count), 32'(expDrop));
        chk("valid", 32'(v_valid), 32'(expQ.size() != 0));
        if (expQ.size() != 0) begin
            e = expQ[0];
            chk("head_addr", 32'(v_addr), 32'(e.a));
            chk("head_data", 32'(v_data), 32'(e.d));
        end else begin
            chk("idle_addr", 32'(v_addr), 32'd0);
            chk("idle_data", 32'(v_data), 32'd0);
        end
        rst = r;
        c_we = we;
        c_addr = addr;
        c_data = data;
        v_ready = rdy;
        if (r) begin
            expQ.delete();
            expDrop = 0;
        end else begin
            pop = (expQ.size() != 0) && rdy;
            hit = we && (addr >= 16'h8000) && (addr <= 16'hF530);
            off = 15'(addr - 16'h8000);
            done = 0;
`ifdef VWQ_COALESCE_EN
            if (hit && expQ.size() != 0 && !(pop && expQ.size() == 1)) begin
                e = expQ[expQ.size()-1];
                if (e.a == off) begin
                    e.d = data;
                    expQ[expQ.size()-1] = e;
                    done = 1;
                end
            end
`endif
            if (hit && !done) begin
                if (expQ.size() < 8 || pop) begin
                    e.a = off;
                    e.d = data;
                    expQ.push_back(e);
                end else if (expDrop < 255) begin
                    expDrop++;
                end
            end
        end
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 16'h0000, 8'h00, rdy, 1'b0);
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] edges [4];
        edges[0] = 16'h7FFF;
        edges[1] = 16'h8000;
        edges[2] = 16'hF530;
        edges[3] = 16'hF531;
        rst = 1'b1;
        c_we = 1'b0;
        c_addr = '0;
        c_data = '0;
        v_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state and the first single write.
        step(1'b1, 16'h8000, 8'hAA, 1'b1, 1'b0);
        chk("rst_level", 32'(level), 32'd0);
        idle(1'b1);
        chk("first_valid", 32'(v_valid), 32'd1);
        chk("first_addr", 32'(v_addr), 32'h0000);
        chk("first_data", 32'(v_data), 32'hAA);
        idle(1'b1);
        chk("first_gone", 32'(v_valid), 32'd0);
        chk("first_level", 32'(level), 32'd0);

        // Window edges.
        step(1'b1, 16'h7FFF, 8'h11, 1'b0, 1'b0);
        step(1'b1, 16'hF531, 8'h22, 1'b0, 1'b0);
        step(1'b1, 16'hF530, 8'h33, 1'b0, 1'b0);
        idle(1'b0);
        chk("edge_level", 32'(level), 32'd1);
        chk("edge_addr", 32'(v_addr), 32'h7530);
        repeat (2) idle(1'b1);

        // Overflow, then full push with simultaneous pop, then drain.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 16'h8100 + 16'(i), 8'(8'h40 + i), 1'b0, 1'b0);
        end
        idle(1'b0);
        chk("ovf_level", 32'(level), 32'd8);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_drops", 32'(drop_count), 32'd2);
        step(1'b1, 16'h8050, 8'h77, 1'b1, 1'b0);
        idle(1'b0);
        chk("fullpop_level", 32'(level), 32'd8);
        chk("fullpop_drops", 32'(drop_count), 32'd2);
        repeat (10) idle(1'b1);
        chk("drained", 32'(level), 32'd0);

        // Reset in the middle of a drain.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 16'h9000 + 16'(i), 8'(i), 1'b0, 1'b0);
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        chk("pre_rst_level", 32'(level), 32'd5);
        step(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1);
        idle(1'b0);
        chk("rst_valid", 32'(v_valid), 32'd0);
        chk("rst_lvl", 32'(level), 32'd0);
        chk("rst_drops", 32'(drop_count), 32'd0);
        chk("rst_addr", 32'(v_addr), 32'd0);

        // Same-offset back-to-back writes.
        step(1'b1, 16'h8010, 8'h01, 1'b0, 1'b0);
        step(1'b1, 16'h8010, 8'h02, 1'b0, 1'b0);
        idle(1'b0);
`ifdef VWQ_COALESCE_EN
        chk("coal_level", 32'(level), 32'd1);
        chk("coal_data", 32'(v_data), 32'h02);
`else
        chk("coal_level", 32'(level), 32'd2);
        chk("coal_data", 32'(v_data), 32'h01);
`endif
        repeat (3) idle(1'b1);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 3))
                0: a = 16'($urandom());
                1: a = 16'h8000 + 16'($urandom_range(0, 3));
                2: a = edges[$urandom_range(0, 3)];
                default: a = 16'($urandom_range(16'h8000, 16'hF530));
            endcase
            step(1'($urandom_range(0, 3) != 0), a, 8'($urandom()),
                 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 99) == 0));
        end

        repeat (12) idle(1'b1);
        chk("final_level", 32'(level), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_write_queue.md
Name: video_write_queue

Overview:
- Parametrised successor to the single-register video write capture.
- Snoops CPU bus writes and filters those inside a configurable video address window.
- Rebases each filtered write to a video-RAM offset and queues it in a DEPTH-entry FIFO.
- Drains the FIFO to video RAM over a valid/ready handshake, so video-side stalls never lose CPU writes until the queue overflows.

Parameters:
- CADDR_W, 16, CPU address width
- DATA_W, 8, data width
- VADDR_W, 15, video RAM address width
- WIN_BASE, 16'h8000, first address of video window (inclusive)
- WIN_LIMIT, 16'hF530, last address of video window (inclusive)
- DEPTH, 8, FIFO entries; power of two, at least 2
- DROP_W, 8, drop counter width

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- c_addr  in  CADDR_W  CPU bus address
- c_data  in  DATA_W  CPU bus write data
- c_we  in  1  CPU write strobe, one write per cycle high
- v_addr  out  VADDR_W  video RAM offset of head entry
- v_data  out  DATA_W  data of head entry
- v_valid  out  1  head entry present
- v_ready  in  1  video RAM accepts head entry this cycle
- full  out  1  FIFO holds DEPTH entries
- level  out  clog2(DEPTH)+1  current entry count
- drop_count  out  DROP_W  saturating count of writes lost to overflow

Behaviour:
- Reset (rst high at a clock edge):
  - Pointers, level, drop_count and v_valid go to 0.
  - full goes to 0; v_addr and v_data go to 0.
  - Reset overrides a push or pop in the same cycle; queued entries are discarded.
- Hit: c_we=1 and WIN_BASE <= c_addr <= WIN_LIMIT, compared unsigned at full CADDR_W.
  - Writes outside the window, or with c_we=0, are ignored and have no side effects.
- Stored offset: (c_addr - WIN_BASE), truncated to the low VADDR_W bits.
  - With the defaults the maximum offset is 15'h7530.
- Push: a hit with level < DEPTH is written at the tail at the clock edge.
- Pop: v_valid && v_ready at a clock edge advances the head.
- Simultaneous push and pop:
  - Both occur and level is unchanged.
  - When full, the push is still accepted because the pop frees a slot.
  - When empty, no pop occurs (v_valid=0) and the push proceeds.
- Overflow: a hit with full=1 and no pop that cycle is dropped.
  - drop_count increments and saturates at all-ones; no entry is modified.
- Output timing:
  - Show-ahead: v_addr, v_data and v_valid are registered and reflect the head entry.
  - A hit at edge N into an empty FIFO gives v_valid=1 with its data during cycle N+1.
  - No combinational path from c_* to v_*.
- While v_valid=0, v_addr and v_data are 0. While v_valid=1 and v_ready=0, outputs hold stable.
- level and full are registered and exact after each edge; full == (level == DEPTH).
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- All outputs are always driven; no tri-state. Bus muxing is the parent's job.

Optional Feature:
- Macro: VWQ_COALESCE_EN
- Defined:
  - A hit whose offset equals the most recently pushed entry overwrites that entry's data in place; no push, level unchanged.
  - Applies only while that entry is still queued and is not the head entry being popped in the same cycle; otherwise a normal push occurs.
  - A coalesced write is never counted as a drop, even when full.
- Undefined: every hit is a separate push; no comparator logic is present.

Test Plan:
- Reset, then c_we=1, c_addr=16'h8000, c_data=8'hAA, v_ready=1 -> next cycle v_valid=1, v_addr=15'h0000, v_data=8'hAA; one cycle later v_valid=0 and level=0.
- Window edges: writes to 16'h7FFF, 16'hF531 and 16'hF530 -> only 16'hF530 is queued, v_addr=15'h7530, level=1.
- v_ready=0, 10 in-window writes with DEPTH=8 -> level=8, full=1, drop_count=2; then v_ready=1 drains 8 entries in push order.
- Full FIFO with v_ready=1 plus a hit in the same cycle -> push accepted, level stays 8, drop_count unchanged.
- rst asserted mid-drain with level=5 -> next cycle v_valid=0, level=0, drop_count=0, v_addr=0.
- VWQ_COALESCE_EN defined, v_ready=0, writes 16'h8010/8'h01 then 16'h8010/8'h02 -> level=1, head v_data=8'h02. With the macro undefined -> level=2.
